// File: rtl/noc_pkg.sv
// Flit layout constants and header helpers shared by the PE network interface.
// Flits are at most FLIT_MAX bits; helpers take the node's address geometry as arguments.
package noc_pkg;

    localparam int STATS_W  = 32;
    localparam int FLIT_MAX = 64;

    // Field offsets for the default 2x2-bit address geometry.
    localparam int X_LSB       = 0;
    localparam int Y_LSB       = 2;
    localparam int PAYLOAD_LSB = 4;

    typedef logic [FLIT_MAX-1:0] flit_bus_t;

    function automatic flit_bus_t field_mask(input int bits);
        return (flit_bus_t'(1) << bits) - flit_bus_t'(1);
    endfunction

    function automatic flit_bus_t build_flit(input flit_bus_t payload, input flit_bus_t dx,
                                             input flit_bus_t dy, input int xs, input int ys);
        return (payload << (xs + ys)) | ((dy & field_mask(ys)) << xs) | ((dx & field_mask(xs)) << X_LSB);
    endfunction

    function automatic flit_bus_t flit_dest_x(input flit_bus_t flit, input int xs);
        return (flit >> X_LSB) & field_mask(xs);
    endfunction

    function automatic flit_bus_t flit_dest_y(input flit_bus_t flit, input int xs, input int ys);
        return (flit >> xs) & field_mask(ys);
    endfunction

    function automatic flit_bus_t flit_payload(input flit_bus_t flit, input int xs, input int ys);
        return flit >> (xs + ys);
    endfunction

endpackage

// File: rtl/ni_fifo.sv
// Synchronous FIFO with a valid/ready stream on both sides; ready and valid come
// straight from the registered occupancy count.
module ni_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ni_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    assign o_ready = (count_q != CW'(DEPTH));
    assign o_valid = (count_q != '0);
    assign o_data  = mem_q[rd_ptr_q];
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = i_data;
        end
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/noc_pe_ni.sv
// Network interface between a PE host stream and its mesh switch local port.
// Define NI_STATS_EN to add the 32-bit traffic counters.
module noc_pe_ni
    import noc_pkg::*;
#(
    parameter int X           = 0,
    parameter int Y           = 0,
    parameter int x_size      = 2,
    parameter int y_size      = 2,
    parameter int data_width  = 32,
    parameter int total_width = 36,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [total_width-1:0] i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [total_width-1:0] o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    input  logic                   i_valid_pci,
    input  logic [data_width-1:0]  i_data_pci,
    input  logic [x_size-1:0]      i_dest_x_pci,
    input  logic [y_size-1:0]      i_dest_y_pci,
    output logic                   o_ready_pci,
    output logic [data_width-1:0]  o_data_pci,
    output logic                   o_valid_pci,
    input  logic                   i_ready_pci
`ifdef NI_STATS_EN
    ,
    output logic [STATS_W-1:0]     o_inj_cnt,
    output logic [STATS_W-1:0]     o_ej_cnt,
    output logic [STATS_W-1:0]     o_lb_cnt,
    output logic [STATS_W-1:0]     o_misroute_cnt
`endif
);

    if (total_width != data_width + x_size + y_size || total_width > FLIT_MAX) begin : g_bad_width
        $error("noc_pe_ni: total_width must equal data_width+x_size+y_size and fit FLIT_MAX");
    end

    function automatic logic is_local(input logic [total_width-1:0] flit);
        return flit_dest_x(flit_bus_t'(flit), x_size) == flit_bus_t'(X) &&
               flit_dest_y(flit_bus_t'(flit), x_size, y_size) == flit_bus_t'(Y);
    endfunction

    logic [total_width-1:0] host_flit, inj_head;
    logic [data_width-1:0]  ej_in;
    logic inj_valid, inj_rdy, ej_ready, ej_push;
    logic head_local, sw_local, sw_xfer, lb_grant;
    logic rr_q, rr_d;

    assign host_flit = total_width'(build_flit(flit_bus_t'(i_data_pci), flit_bus_t'(i_dest_x_pci),
                                               flit_bus_t'(i_dest_y_pci), x_size, y_size));

    ni_fifo #(.WIDTH(total_width), .DEPTH(FIFO_DEPTH)) u_inj_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_data  (host_flit),
        .i_valid (i_valid_pci),
        .o_ready (o_ready_pci),
        .o_data  (inj_head),
        .o_valid (inj_valid),
        .i_ready (inj_rdy)
    );

    // Self-addressed heads never reach the switch; they compete for the ejection FIFO instead.
    assign head_local = inj_valid && is_local(inj_head);
    assign sw_local   = is_local(i_data);
    assign lb_grant   = head_local && ej_ready && (rr_q || !i_valid);
    assign o_ready    = ej_ready && !(head_local && rr_q);
    assign sw_xfer    = i_valid && o_ready;
    assign o_valid    = inj_valid && !head_local;
    assign o_data     = inj_head;
    assign inj_rdy    = (i_ready && !head_local) || lb_grant;
    assign ej_push    = lb_grant || (sw_xfer && sw_local);
    assign ej_in      = lb_grant ? data_width'(flit_payload(flit_bus_t'(inj_head), x_size, y_size))
                                 : data_width'(flit_payload(flit_bus_t'(i_data), x_size, y_size));

    always_comb begin
        rr_d = rr_q;
        if (sw_xfer) begin
            rr_d = 1'b1;
        end else if (lb_grant) begin
            rr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    ni_fifo #(.WIDTH(data_width), .DEPTH(FIFO_DEPTH)) u_ej_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_data  (ej_in),
        .i_valid (ej_push),
        .o_ready (ej_ready),
        .o_data  (o_data_pci),
        .o_valid (o_valid_pci),
        .i_ready (i_ready_pci)
    );

`ifdef NI_STATS_EN
    logic [STATS_W-1:0] inj_cnt_q, inj_cnt_d, ej_cnt_q, ej_cnt_d;
    logic [STATS_W-1:0] lb_cnt_q, lb_cnt_d, misroute_cnt_q, misroute_cnt_d;

    always_comb begin
        inj_cnt_d      = inj_cnt_q + STATS_W'(i_valid_pci && o_ready_pci);
        ej_cnt_d       = ej_cnt_q + STATS_W'(o_valid_pci && i_ready_pci);
        lb_cnt_d       = lb_cnt_q + STATS_W'(lb_grant);
        misroute_cnt_d = misroute_cnt_q + STATS_W'(sw_xfer && !sw_local);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inj_cnt_q      <= '0;
            ej_cnt_q       <= '0;
            lb_cnt_q       <= '0;
            misroute_cnt_q <= '0;
        end else begin
            inj_cnt_q      <= inj_cnt_d;
            ej_cnt_q       <= ej_cnt_d;
            lb_cnt_q       <= lb_cnt_d;
            misroute_cnt_q <= misroute_cnt_d;
        end
    end

    assign o_inj_cnt      = inj_cnt_q;
    assign o_ej_cnt       = ej_cnt_q;
    assign o_lb_cnt       = lb_cnt_q;
    assign o_misroute_cnt = misroute_cnt_q;
`endif

endmodule

// File: tb/tb_noc_pe_ni.sv
// Self-checking bench for noc_pe_ni at node (1,1) with default widths; a queue-based
// model predicts every output each cycle. Works with or without NI_STATS_EN.
module tb_noc_pe_ni;

    localparam int NX = 1;
    localparam int NY = 1;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [35:0] i_data = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [35:0] o_data;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic        i_valid_pci = 1'b0;
    logic [31:0] i_data_pci = '0;
    logic [1:0]  i_dest_x_pci = '0;
    logic [1:0]  i_dest_y_pci = '0;
    logic        o_ready_pci;
    logic [31:0] o_data_pci;
    logic        o_valid_pci;
    logic        i_ready_pci = 1'b0;
`ifdef NI_STATS_EN
    logic [31:0] o_inj_cnt, o_ej_cnt, o_lb_cnt, o_misroute_cnt;
`endif

    always #5 clk = ~clk;

    noc_pe_ni #(
        .X(NX), .Y(NY), .x_size(2), .y_size(2), .data_width(32), .total_width(36), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .i_valid_pci  (i_valid_pci),
        .i_data_pci   (i_data_pci),
        .i_dest_x_pci (i_dest_x_pci),
        .i_dest_y_pci (i_dest_y_pci),
        .o_ready_pci  (o_ready_pci),
        .o_data_pci   (o_data_pci),
        .o_valid_pci  (o_valid_pci),
        .i_ready_pci  (i_ready_pci)
`ifdef NI_STATS_EN
        ,
        .o_inj_cnt      (o_inj_cnt),
        .o_ej_cnt       (o_ej_cnt),
        .o_lb_cnt       (o_lb_cnt),
        .o_misroute_cnt (o_misroute_cnt)
`endif
    );

    typedef struct {
        logic [31:0] pl;
        logic [1:0]  dx;
        logic [1:0]  dy;
    } word_t;

    // Reference model: what each FIFO holds, whose turn it is, and the traffic counts.
    word_t       inj_m[$];
    logic [31:0] ej_m[$];
    bit          turn_lb;
    int unsigned m_inj_cnt, m_ej_cnt, m_lb_cnt, m_mis_cnt;
    bit          host_acc, sw_acc;

    int          tests = 0;
    int          fails = 0;
    bit          check_en = 1'b0;
    int          n_out = 0;
    logic [31:0] del_log[$];

    int p_host = 0, p_sw = 0, p_ird = 100, p_irdpci = 100, p_rst = 0;
    int host_dest_mode = 0, sw_dest_mode = 0;
    bit tag_mode = 1'b0;
    int seq = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit m_head_local();
        return inj_m.size() > 0 && inj_m[0].dx == 2'(NX) && inj_m[0].dy == 2'(NY);
    endfunction

    function automatic bit m_ready_sw();
        return ej_m.size() < DEPTH && !(m_head_local() && turn_lb);
    endfunction

    task automatic checkOutput();
        if (!check_en) return;
        check("o_ready_pci", 64'(o_ready_pci), 64'(inj_m.size() < DEPTH));
        check("o_valid", 64'(o_valid), 64'(inj_m.size() > 0 && !m_head_local()));
        check("o_ready", 64'(o_ready), 64'(m_ready_sw()));
        check("o_valid_pci", 64'(o_valid_pci), 64'(ej_m.size() > 0));
        if (inj_m.size() > 0 && !m_head_local())
            check("o_data", 64'(o_data), 64'({inj_m[0].pl, inj_m[0].dy, inj_m[0].dx}));
        if (ej_m.size() > 0)
            check("o_data_pci", 64'(o_data_pci), 64'(ej_m[0]));
`ifdef NI_STATS_EN
        check("o_inj_cnt", 64'(o_inj_cnt), 64'(m_inj_cnt));
        check("o_ej_cnt", 64'(o_ej_cnt), 64'(m_ej_cnt));
        check("o_lb_cnt", 64'(o_lb_cnt), 64'(m_lb_cnt));
        check("o_misroute_cnt", 64'(o_misroute_cnt), 64'(m_mis_cnt));
`endif
    endtask

    task automatic model_update();
        bit    lb, inj_out, host_out, hl;
        word_t w;
        if (rst) begin
            inj_m.delete();
            ej_m.delete();
            turn_lb = 1'b0;
            {m_inj_cnt, m_ej_cnt, m_lb_cnt, m_mis_cnt} = '0;
            host_acc = 1'b0;
            sw_acc = 1'b0;
            return;
        end
        hl       = m_head_local();
        host_acc = i_valid_pci && inj_m.size() < DEPTH;
        sw_acc   = i_valid && m_ready_sw();
        lb       = hl && ej_m.size() < DEPTH && (turn_lb || !i_valid);
        inj_out  = inj_m.size() > 0 && !hl && i_ready;
        host_out = ej_m.size() > 0 && i_ready_pci;
        if (host_out) begin
            void'(ej_m.pop_front());
            m_ej_cnt++;
        end
        if (inj_out || lb) w = inj_m.pop_front();
        if (lb) begin
            ej_m.push_back(w.pl);
            m_lb_cnt++;
            turn_lb = 1'b0;
        end
        if (sw_acc) begin
            if (i_data[1:0] == 2'(NX) && i_data[3:2] == 2'(NY)) ej_m.push_back(i_data[35:4]);
            else m_mis_cnt++;
            turn_lb = 1'b1;
        end
        if (host_acc) begin
            inj_m.push_back('{pl: i_data_pci, dx: i_dest_x_pci, dy: i_dest_y_pci});
            m_inj_cnt++;
        end
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        @(negedge clk);
        checkOutput();
        if (check_en && !rst) begin
            if (o_valid === 1'b1 && i_ready) n_out++;
            if (o_valid_pci === 1'b1 && i_ready_pci) del_log.push_back(o_data_pci);
        end
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        if (!i_valid_pci || host_acc) begin
            i_valid_pci = ($urandom_range(0, 99) < p_host);
            if (i_valid_pci) begin
                seq++;
                i_data_pci = tag_mode ? {8'hB0, 24'(seq)} : $urandom;
                if (host_dest_mode == 2 || $urandom_range(0, 2) == 0) begin
                    i_dest_x_pci = 2'(NX);
                    i_dest_y_pci = 2'(NY);
                end else begin
                    i_dest_x_pci = 2'($urandom_range(0, 3));
                    i_dest_y_pci = 2'($urandom_range(0, 3));
                end
            end
        end
        if (!i_valid || sw_acc) begin
            i_valid = ($urandom_range(0, 99) < p_sw);
            if (i_valid) begin
                seq++;
                i_data[35:4] = tag_mode ? {8'hC0, 24'(seq)} : $urandom;
                if (sw_dest_mode == 0 && $urandom_range(0, 3) == 0) i_data[3:0] = 4'($urandom_range(0, 15));
                else i_data[3:0] = {2'(NY), 2'(NX)};
            end
        end
        i_ready     = ($urandom_range(0, 99) < p_ird);
        i_ready_pci = ($urandom_range(0, 99) < p_irdpci);
        rst         = (p_rst > 0) && ($urandom_range(0, 999) < p_rst);
    endtask

    task automatic run_random(input int n);
        repeat (n) begin
            applyStimulus();
            step();
        end
    endtask

    task automatic host_send(input logic [31:0] d, input logic [1:0] dx, input logic [1:0] dy);
        i_valid_pci = 1'b1;
        i_data_pci = d;
        i_dest_x_pci = dx;
        i_dest_y_pci = dy;
        for (int k = 0; k < 40; k++) begin
            step();
            if (host_acc) break;
        end
        if (!host_acc) check("host_send_timeout", 64'd0, 64'd1);
        i_valid_pci = 1'b0;
    endtask

    task automatic sw_send(input logic [35:0] f, output int cycles);
        i_valid = 1'b1;
        i_data = f;
        cycles = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            cycles++;
            if (sw_acc) break;
        end
        if (!sw_acc) check("sw_send_timeout", 64'd0, 64'd1);
        i_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base, cyc;
        bit alt_ok;

        rst = 1'b1;
        step();
        check_en = 1'b1;
        rst = 1'b0;
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_valid_pci", 64'(o_valid_pci), 64'd0);
        check("rst_o_ready", 64'(o_ready), 64'd1);
        check("rst_o_ready_pci", 64'(o_ready_pci), 64'd1);

        $display("[TB] remote injection");
        host_send(32'hA5A5A5A5, 2'd2, 2'd0);
        check("inj_valid_next", 64'(o_valid), 64'd1);
        check("inj_flit", 64'(o_data), 64'h0_A5A5_A5A52);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;

        $display("[TB] injection backpressure");
        base = n_out;
        for (int k = 0; k < 8; k++) host_send(32'h100 + k, 2'd3, 2'd2);
        check("inj_full_ready", 64'(o_ready_pci), 64'd0);
        i_valid_pci = 1'b1;
        i_data_pci = 32'h999;
        step();
        step();
        check("inj_full_hold", 64'(o_ready_pci), 64'd0);
        i_ready = 1'b1;
        for (int k = 0; k < 20 && !host_acc; k++) step();
        i_valid_pci = 1'b0;
        repeat (12) step();
        check("inj_drained_count", 64'(n_out - base), 64'd9);
        check("inj_ready_back", 64'(o_ready_pci), 64'd1);

        $display("[TB] ejection backpressure");
        base = del_log.size();
        for (int k = 0; k < 8; k++) sw_send({32'h12345678 + k, 2'd1, 2'd1}, cyc);
        check("ej_full_ready", 64'(o_ready), 64'd0);
        check("ej_head_payload", 64'(o_data_pci), 64'h12345678);
        i_ready_pci = 1'b1;
        repeat (10) step();
        check("ej_drained_count", 64'(del_log.size() - base), 64'd8);
        if (del_log.size() >= base + 8) check("ej_last_payload", 64'(del_log[base+7]), 64'h1234567F);

        $display("[TB] loopback versus switch");
        base = del_log.size();
        tag_mode = 1'b1;
        host_dest_mode = 2;
        sw_dest_mode = 1;
        p_host = 100;
        p_sw = 100;
        p_ird = 100;
        p_irdpci = 100;
        repeat (24) begin
            applyStimulus();
            step();
            check("lb_no_switch_out", 64'(o_valid), 64'd0);
        end
        p_host = 0;
        p_sw = 0;
        run_random(30);
        alt_ok = (del_log.size() >= base + 16);
        for (int k = 0; k < 16 && alt_ok; k++)
            if (del_log[base+k][31:24] != ((k % 2 == 0) ? 8'hC0 : 8'hB0)) alt_ok = 1'b0;
        check("lb_alternation", 64'(alt_ok), 64'd1);
        tag_mode = 1'b0;
        host_dest_mode = 0;
        sw_dest_mode = 0;

        $display("[TB] misroute");
        sw_send({32'hDEAD0001, 2'd3, 2'd0}, cyc);
        check("misroute_accept_cycles", 64'(cyc), 64'd1);
        repeat (3) step();
        check("misroute_no_eject", 64'(o_valid_pci), 64'd0);
`ifdef NI_STATS_EN
        check("misroute_count", 64'(o_misroute_cnt), 64'd1);
`endif

        $display("[TB] reset mid-traffic");
        i_ready = 1'b0;
        i_ready_pci = 1'b0;
        for (int k = 0; k < 4; k++) host_send(32'h5000 + k, 2'd0, 2'd2);
        for (int k = 0; k < 4; k++) sw_send({32'h6000 + k, 2'd1, 2'd1}, cyc);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_o_valid", 64'(o_valid), 64'd0);
        check("midrst_o_valid_pci", 64'(o_valid_pci), 64'd0);
        check("midrst_o_ready", 64'(o_ready), 64'd1);
`ifdef NI_STATS_EN
        check("midrst_inj_cnt", 64'(o_inj_cnt), 64'd0);
`endif
        base = del_log.size();
        cyc = n_out;
        i_ready = 1'b1;
        i_ready_pci = 1'b1;
        repeat (10) step();
        check("midrst_no_stale_pci", 64'(del_log.size() - base), 64'd0);
        check("midrst_no_stale_sw", 64'(n_out - cyc), 64'd0);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 8; c++) begin
            p_host = $urandom_range(20, 100);
            p_sw = $urandom_range(20, 100);
            p_ird = $urandom_range(10, 100);
            p_irdpci = $urandom_range(10, 100);
            p_rst = (c == 5) ? 5 : 0;
            run_random(300);
        end
        p_host = 0;
        p_sw = 0;
        p_ird = 100;
        p_irdpci = 100;
        p_rst = 0;
        run_random(60);
        check("final_inj_empty", 64'(o_valid), 64'd0);
        check("final_ej_empty", 64'(o_valid_pci), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
